// File: rtl/arbitro_memoria_dados_pkg.sv
// Shared definitions for the two-port data-memory arbiter: state encoding and default width.
package arbitro_memoria_dados_pkg;

  localparam int LARGURA_PADRAO = 32;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ATENDE  = 2'd1,
    ESPERA  = 2'd2,
    CONCLUI = 2'd3
  } estado_t;

  // States in which the memory bus carries the latched address and data.
  function automatic logic em_acesso(input estado_t e);
    return (e == ATENDE) || (e == ESPERA);
  endfunction

endpackage

// File: rtl/arbitro_memoria_dados_seletor_rr.sv
// Two-way round-robin selector: a lone requester wins; on a tie the port not served last wins.
module arbitro_memoria_dados_seletor_rr (
  input  logic req0,
  input  logic req1,
  input  logic ultimo,
  output logic concede,
  output logic vencedor
);

  assign concede  = req0 | req1;
  assign vencedor = (req0 && req1) ? ~ultimo : req1;

endmodule

// File: rtl/arbitro_memoria_dados.sv
// Arbitrates two requesters (CPU, DMA/debug) onto one data memory; all outputs are registered.
// Handshake: req (with we/end/dado) is sampled only at the grant edge; ack pulses once per transaction.
module arbitro_memoria_dados
  import arbitro_memoria_dados_pkg::*;
#(
  parameter int LARGURA          = LARGURA_PADRAO,
  parameter int LATENCIA_LEITURA = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic               we0,
  input  logic               we1,
  input  logic [LARGURA-1:0] end0,
  input  logic [LARGURA-1:0] end1,
  input  logic [LARGURA-1:0] dado0,
  input  logic [LARGURA-1:0] dado1,
  output logic               ack0,
  output logic               ack1,
  output logic [LARGURA-1:0] lido0,
  output logic [LARGURA-1:0] lido1,
  output logic               mem_memRead,
  output logic               mem_memWrite,
  output logic [LARGURA-1:0] mem_endereco,
  output logic [LARGURA-1:0] mem_dadoEscrita,
  input  logic [LARGURA-1:0] mem_dadoLido,
  output logic               ocupado,
  output logic [1:0]         estado_dbg
);

  localparam logic [1:0] ULTIMO_CICLO = 2'(LATENCIA_LEITURA - 1);

  estado_t             estado, prox;
  logic [1:0]          contador, prox_contador;
  logic                porta, prox_porta;
  logic                ultimo;
  logic                lat_we, prox_we;
  logic [LARGURA-1:0]  lat_end, prox_end;
  logic [LARGURA-1:0]  lat_dado, prox_dado;
  logic                concede, vencedor;
  logic                captura;

  arbitro_memoria_dados_seletor_rr u_seletor (
    .req0     (req0),
    .req1     (req1),
    .ultimo   (ultimo),
    .concede  (concede),
    .vencedor (vencedor)
  );

  assign estado_dbg = estado;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado   <= OCIOSO;
      contador <= '0;
      porta    <= 1'b0;
      ultimo   <= 1'b1;
      lat_we   <= 1'b0;
      lat_end  <= '0;
      lat_dado <= '0;
    end else begin
      estado   <= prox;
      contador <= prox_contador;
      porta    <= prox_porta;
      lat_we   <= prox_we;
      lat_end  <= prox_end;
      lat_dado <= prox_dado;
      if (estado == CONCLUI) ultimo <= porta;
    end
  end

  always_comb begin
    prox          = estado;
    prox_contador = contador;
    prox_porta    = porta;
    prox_we       = lat_we;
    prox_end      = lat_end;
    prox_dado     = lat_dado;
    captura       = 1'b0;
    case (estado)
      OCIOSO: begin
        if (concede) begin
          prox       = ATENDE;
          prox_porta = vencedor;
          prox_we    = vencedor ? we1   : we0;
          prox_end   = vencedor ? end1  : end0;
          prox_dado  = vencedor ? dado1 : dado0;
        end
      end
      ATENDE: begin
        if (lat_we) begin
          prox = CONCLUI;
        end else begin
          prox          = ESPERA;
          prox_contador = '0;
        end
      end
      ESPERA: begin
        if (contador == ULTIMO_CICLO) begin
          prox    = CONCLUI;
          captura = 1'b1;
        end else begin
          prox_contador = contador + 2'd1;
        end
      end
      CONCLUI: prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack0            <= 1'b0;
      ack1            <= 1'b0;
      lido0           <= '0;
      lido1           <= '0;
      mem_memRead     <= 1'b0;
      mem_memWrite    <= 1'b0;
      mem_endereco    <= '0;
      mem_dadoEscrita <= '0;
      ocupado         <= 1'b0;
    end else begin
      mem_memWrite    <= (prox == ATENDE) && prox_we;
      mem_memRead     <= ((prox == ATENDE) && !prox_we) || (prox == ESPERA);
      mem_endereco    <= em_acesso(prox) ? prox_end  : '0;
      mem_dadoEscrita <= em_acesso(prox) ? prox_dado : '0;
      ack0            <= (prox == CONCLUI) && !prox_porta;
      ack1            <= (prox == CONCLUI) && prox_porta;
      ocupado         <= (prox != OCIOSO);
      if (captura && !porta) lido0 <= mem_dadoLido;
      if (captura && porta)  lido1 <= mem_dadoLido;
    end
  end

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Self-checking bench for arbitro_memoria_dados: random transactions against a memory/arbitration model.
module tb_arbitro_memoria_dados;

  localparam int LARGURA = 32;
  localparam int LAT     = 1;
  localparam int TIMEOUT = 40;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic               req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [LARGURA-1:0] end0 = '0, end1 = '0, dado0 = '0, dado1 = '0;
  logic               ack0, ack1, mem_memRead, mem_memWrite, ocupado;
  logic [LARGURA-1:0] lido0, lido1, mem_endereco, mem_dadoEscrita, mem_dadoLido;
  logic [1:0]         estado_dbg;

  arbitro_memoria_dados #(.LARGURA(LARGURA), .LATENCIA_LEITURA(LAT)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .end0(end0), .end1(end1), .dado0(dado0), .dado1(dado1),
    .ack0(ack0), .ack1(ack1), .lido0(lido0), .lido1(lido1),
    .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
    .mem_endereco(mem_endereco), .mem_dadoEscrita(mem_dadoEscrita),
    .mem_dadoLido(mem_dadoLido), .ocupado(ocupado), .estado_dbg(estado_dbg)
  );

  // Behavioural memory standing in for memoria_dados.
  logic [LARGURA-1:0] mem [0:255];
  assign mem_dadoLido = mem[mem_endereco[7:0]];
  always @(posedge clock) if (mem_memWrite) mem[mem_endereco[7:0]] <= mem_dadoEscrita;

  // ---------------- reference model / scoreboard ----------------
  int                 checks = 0;
  int                 failures = 0;
  logic [LARGURA-1:0] ref_mem [int];
  logic [LARGURA-1:0] exp_lido [2];
  int                 ultima_porta = 1;
  logic [0:0]         exp_q [$];

  function automatic logic [LARGURA-1:0] ref_read(input logic [LARGURA-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  task automatic model_reset();
    ultima_porta = 1;
    exp_lido[0]  = '0;
    exp_lido[1]  = '0;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if ((ack0 && ack1) || (mem_memRead && mem_memWrite)) begin
        failures++;
        $display("FAIL exclusivity t=%0t ack0=%b ack1=%b rd=%b wr=%b", $time, ack0, ack1, mem_memRead, mem_memWrite);
      end
      checks++;
      if (!ocupado && (mem_memRead || mem_memWrite || mem_endereco !== '0 || mem_dadoEscrita !== '0)) begin
        failures++;
        $display("FAIL idle_bus t=%0t rd=%b wr=%b end=%h dado=%h", $time, mem_memRead, mem_memWrite, mem_endereco, mem_dadoEscrita);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int p, input logic r, input logic w, input logic [LARGURA-1:0] a, input logic [LARGURA-1:0] d);
    if (p == 0) begin req0 = r; we0 = w; end0 = a; dado0 = d; end
    else        begin req1 = r; we1 = w; end1 = a; dado1 = d; end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    model_reset();
  endtask

  // One transaction from an idle arbiter; req dropped after grant, fields optionally scrambled.
  task automatic transacao(input int p, input logic w, input logic [LARGURA-1:0] a, input logic [LARGURA-1:0] d,
                           input logic scramble, output int ack_edge, output int n_rd, output int n_wr,
                           output logic [LARGURA-1:0] end_seen, output logic [LARGURA-1:0] dado_seen);
    logic ackv;
    set_req(p, 1'b1, w, a, d);
    @(posedge clock); #1;
    if (scramble) set_req(p, 1'b0, ~w, $urandom, $urandom);
    else          set_req(p, 1'b0, w, a, d);
    ack_edge = -1; n_rd = 0; n_wr = 0; end_seen = '0; dado_seen = '0;
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clock);
      if (mem_memWrite) begin n_wr++; end_seen = mem_endereco; dado_seen = mem_dadoEscrita; end
      if (mem_memRead)  begin n_rd++; end_seen = mem_endereco; end
      ackv = (p == 0) ? ack0 : ack1;
      if (ackv) begin ack_edge = k + 1; break; end
      @(posedge clock);
    end
    @(posedge clock); #1;
  endtask

  // Both ports request reads; acks are scored against exp_q in arrival order.
  task automatic run_both(input int n, input logic drop_on_ack, input logic [LARGURA-1:0] a0, input logic [LARGURA-1:0] a1);
    int got;
    int p;
    logic [0:0] exp_p;
    got = 0;
    set_req(0, 1'b1, 1'b0, a0, '0);
    set_req(1, 1'b1, 1'b0, a1, '0);
    for (int c = 0; c < TIMEOUT * n && got < n; c++) begin
      @(negedge clock);
      if (ack0 || ack1) begin
        p = ack1 ? 1 : 0;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rr_order unexpected ack port=%0d", p);
        end else begin
          exp_p = exp_q.pop_front();
          if (1'(p) !== exp_p) begin
            failures++;
            $display("FAIL rr_order ack %0d: got port %0d expected port %0d", got, p, exp_p);
          end
        end
        exp_lido[p]  = ref_read(p == 1 ? a1 : a0);
        ultima_porta = p;
        checks++;
        if (lido0 !== exp_lido[0] || lido1 !== exp_lido[1]) begin
          failures++;
          $display("FAIL rr_lido got %h/%h expected %h/%h", lido0, lido1, exp_lido[0], exp_lido[1]);
        end
        got++;
        if (drop_on_ack) set_req(p, 1'b0, 1'b0, p == 1 ? a1 : a0, '0);
        if (got == n) begin
          set_req(0, 1'b0, 1'b0, a0, '0);
          set_req(1, 1'b0, 1'b0, a1, '0);
        end
      end
    end
    checks++;
    if (got != n) begin
      failures++;
      $display("FAIL rr_timeout got %0d acks expected %0d", got, n);
    end
    set_req(0, 1'b0, 1'b0, a0, '0);
    set_req(1, 1'b0, 1'b0, a1, '0);
    exp_q.delete();
    @(posedge clock); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    req0 = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({ocupado, ack0, ack1, mem_memRead, mem_memWrite} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got %b expected 00000", {ocupado, ack0, ack1, mem_memRead, mem_memWrite});
    end
    checks++;
    if (lido0 !== '0 || lido1 !== '0 || mem_endereco !== '0 || mem_dadoEscrita !== '0) begin
      failures++;
      $display("FAIL reset_data lido=%h/%h end=%h dado=%h expected zeros", lido0, lido1, mem_endereco, mem_dadoEscrita);
    end
    req0  = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    model_reset();
  endtask

  task automatic test_write_read();
    int ae, nr, nw;
    logic [LARGURA-1:0] es, ds;
    transacao(0, 1'b1, 32'd4, 32'hA5A5A5A5, 1'b0, ae, nr, nw, es, ds);
    ref_mem[4] = 32'hA5A5A5A5; ultima_porta = 0;
    checks++;
    if (ae !== 2) begin failures++; $display("FAIL write_latency got %0d expected 2", ae); end
    checks++;
    if (nw !== 1 || nr !== 0) begin failures++; $display("FAIL write_strobe wr=%0d rd=%0d expected 1/0", nw, nr); end
    checks++;
    if (es !== 32'd4 || ds !== 32'hA5A5A5A5) begin failures++; $display("FAIL write_bus end=%h dado=%h expected 4/a5a5a5a5", es, ds); end
    transacao(0, 1'b0, 32'd4, '0, 1'b0, ae, nr, nw, es, ds);
    exp_lido[0] = ref_read(32'd4);
    checks++;
    if (ae !== 2 + LAT) begin failures++; $display("FAIL read_latency got %0d expected %0d", ae, 2 + LAT); end
    checks++;
    if (nr !== LAT + 1 || nw !== 0) begin failures++; $display("FAIL read_strobe rd=%0d wr=%0d expected %0d/0", nr, nw, LAT + 1); end
    checks++;
    if (lido0 !== exp_lido[0] || lido1 !== exp_lido[1]) begin
      failures++; $display("FAIL read_data lido=%h/%h expected %h/%h", lido0, lido1, exp_lido[0], exp_lido[1]);
    end
  endtask

  task automatic test_tie();
    int ae, nr, nw;
    logic [LARGURA-1:0] es, ds;
    transacao(1, 1'b1, 32'd5, 32'h5A5A1234, 1'b0, ae, nr, nw, es, ds);
    ref_mem[5] = 32'h5A5A1234;
    checks++;
    if (ae !== 2) begin failures++; $display("FAIL tie_setup_latency got %0d expected 2", ae); end
    apply_reset();
    exp_q.push_back(1'(1 - ultima_porta));
    exp_q.push_back(1'(ultima_porta));
    run_both(2, 1'b1, 32'd4, 32'd5);
  endtask

  task automatic test_alternate();
    int u;
    u = ultima_porta;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(1'(1 - u));
      u = 1 - u;
    end
    run_both(4, 1'b0, 32'd4, 32'd5);
  endtask

  task automatic test_reset_abort();
    int ae, nr, nw;
    logic [LARGURA-1:0] es, ds;
    set_req(1, 1'b1, 1'b0, 32'd5, '0);
    @(posedge clock); #1;
    set_req(1, 1'b0, 1'b0, 32'd5, '0);
    @(posedge clock); #1;
    checks++;
    if (mem_memRead !== 1'b1 || ocupado !== 1'b1) begin
      failures++; $display("FAIL abort_setup rd=%b ocupado=%b expected 1/1", mem_memRead, ocupado);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_memRead, mem_memWrite, ocupado, ack1} !== 4'b0 || lido1 !== '0) begin
      failures++; $display("FAIL abort_async flags=%b lido1=%h expected 0000/0", {mem_memRead, mem_memWrite, ocupado, ack1}, lido1);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (ack1 !== 1'b0 || lido1 !== '0) begin
        failures++; $display("FAIL abort_no_ack cycle %0d ack1=%b lido1=%h expected 0/0", i, ack1, lido1);
      end
    end
    @(posedge clock); #1;
    transacao(1, 1'b0, 32'd5, '0, 1'b0, ae, nr, nw, es, ds);
    exp_lido[1] = ref_read(32'd5); ultima_porta = 1;
    checks++;
    if (ae !== 2 + LAT || lido1 !== exp_lido[1]) begin
      failures++; $display("FAIL abort_recover latency=%0d lido1=%h expected %0d/%h", ae, lido1, 2 + LAT, exp_lido[1]);
    end
  endtask

  task automatic test_drop_scramble();
    int ae, nr, nw;
    logic [LARGURA-1:0] es, ds, d;
    d = $urandom;
    transacao(1, 1'b1, 32'd7, d, 1'b1, ae, nr, nw, es, ds);
    ref_mem[7] = d; ultima_porta = 1;
    checks++;
    if (ae !== 2 || nw !== 1) begin failures++; $display("FAIL drop_ack latency=%0d wr=%0d expected 2/1", ae, nw); end
    checks++;
    if (es !== 32'd7 || ds !== d) begin failures++; $display("FAIL drop_fields end=%h dado=%h expected 7/%h", es, ds, d); end
    checks++;
    if (mem[7] !== d) begin failures++; $display("FAIL drop_memory mem[7]=%h expected %h", mem[7], d); end
    transacao(0, 1'b0, 32'd7, '0, 1'b0, ae, nr, nw, es, ds);
    exp_lido[0] = ref_read(32'd7); ultima_porta = 0;
    checks++;
    if (lido0 !== exp_lido[0]) begin failures++; $display("FAIL drop_readback lido0=%h expected %h", lido0, exp_lido[0]); end
  endtask

  task automatic test_random();
    int ae, nr, nw, p;
    logic w, sc;
    logic [LARGURA-1:0] a, d, es, ds;
    for (int i = 0; i < 24; i++) begin
      p  = int'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      sc = 1'($urandom_range(0, 1));
      a  = LARGURA'($urandom_range(0, 15));
      d  = $urandom;
      transacao(p, w, a, d, sc, ae, nr, nw, es, ds);
      checks++;
      if (ae !== (w ? 2 : 2 + LAT)) begin
        failures++; $display("FAIL rand_latency iter %0d got %0d expected %0d", i, ae, w ? 2 : 2 + LAT);
      end
      checks++;
      if ((w && (nw !== 1 || nr !== 0)) || (!w && (nr !== LAT + 1 || nw !== 0))) begin
        failures++; $display("FAIL rand_strobe iter %0d wr=%0d rd=%0d we=%b", i, nw, nr, w);
      end
      checks++;
      if (es !== a) begin failures++; $display("FAIL rand_addr iter %0d got %h expected %h", i, es, a); end
      if (w) begin
        checks++;
        if (ds !== d) begin failures++; $display("FAIL rand_wdata iter %0d got %h expected %h", i, ds, d); end
        ref_mem[int'(a)] = d;
      end else begin
        exp_lido[p] = ref_read(a);
      end
      ultima_porta = p;
      checks++;
      if (lido0 !== exp_lido[0] || lido1 !== exp_lido[1]) begin
        failures++; $display("FAIL rand_lido iter %0d got %h/%h expected %h/%h", i, lido0, lido1, exp_lido[0], exp_lido[1]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_write_read();
    test_tie();
    test_alternate();
    test_reset_abort();
    test_drop_scramble();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "global timeout");
  end

endmodule
